regfile_mp: RTL

Parametrised multi-port register file, the next-generation datapath register bank. Provides:
- Two general read ports and a dedicated special-register read.
- Two general write ports and a dedicated special-register write, with fixed write priority.
- A per-register pending scoreboard for in-flight destinations.
Sits between decode (read/issue) and writeback in the datapath.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wr_arb.sv | 63 ++++++
 rtl/regfile_mp.sv | 104 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the multi-port register file.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths.
//   SPECIAL_IDX_DEF         : default index of the special register.
//   data_t / addr_t         : word and address types at the default widths.
package regfile_pkg;

  localparam int DATA_W_DEF      = 16;
  localparam int ADDR_W_DEF      = 4;
  localparam int SPECIAL_IDX_DEF = 15;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: combinational write arbiter for regfile_mp.
// It resolves the three write sources (wr0 > wr1 > sp) into per-register
// enables and data, and flags same-target collisions.
//   wr0_*, wr1_*   : general write requests.
//   sp_we/sp_wdata : special-register write, always targets SPECIAL_IDX.
//   we/wdata       : one-hot-per-register winning write.
//   conflict       : two or more enabled sources hit the same register.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SPECIAL_IDX = SPECIAL_IDX_DEF,
  parameter int ZERO_REG    = 0,
  localparam int DEPTH      = 2**ADDR_W
) (
  input  logic                           wr0_en,
  input  logic [ADDR_W-1:0]              wr0_addr,
  input  logic [DATA_W-1:0]              wr0_data,
  input  logic                           wr1_en,
  input  logic [ADDR_W-1:0]              wr1_addr,
  input  logic [DATA_W-1:0]              wr1_data,
  input  logic                           sp_we,
  input  logic [DATA_W-1:0]              sp_wdata,
  output logic [DEPTH-1:0]               we,
  output logic [DEPTH-1:0][DATA_W-1:0]   wdata,
  output logic                           conflict
);

  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SPECIAL_IDX);

  logic e0, e1, es;

  // Writes to a hardwired zero register are dropped before arbitration so
  // they neither commit nor count as collisions.
  always_comb begin
    e0 = wr0_en && !((ZERO_REG != 0) && (wr0_addr == '0));
    e1 = wr1_en && !((ZERO_REG != 0) && (wr1_addr == '0));
    es = sp_we  && !((ZERO_REG != 0) && (SP_ADDR == '0));
  end

  assign conflict = (e0 && e1 && (wr0_addr == wr1_addr)) ||
                    (e0 && es && (wr0_addr == SP_ADDR))  ||
                    (e1 && es && (wr1_addr == SP_ADDR));

  always_comb begin
    we    = '0;
    wdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e0 && (wr0_addr == ADDR_W'(i))) begin
        we[i]    = 1'b1;
        wdata[i] = wr0_data;
      end else if (e1 && (wr1_addr == ADDR_W'(i))) begin
        we[i]    = 1'b1;
        wdata[i] = wr1_data;
      end else if (es && (SP_ADDR == ADDR_W'(i))) begin
        we[i]    = 1'b1;
        wdata[i] = sp_wdata;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with pending scoreboard.
// Two combinational read ports (data + ready), a special-register read,
// two general write ports plus a special write (priority wr0 > wr1 > sp),
// and a per-register pending bit set on issue and cleared by a committed
// write. wr_conflict is a registered one-cycle collision pulse.
// Optional build macro REGFILE_MP_BYPASS_EN forwards the committing write
// data (and ready) to the read ports in the same cycle.
//   clk, rst (async, active-low)
//   rd_addr_a/b -> rd_data_a/b, rd_rdy_a/b ; sp_rdata
//   wr0_*, wr1_*, sp_we/sp_wdata ; iss_en/iss_addr ; wr_conflict
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SPECIAL_IDX = SPECIAL_IDX_DEF,
  parameter int ZERO_REG    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_rdy_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_rdy_b,
  output logic [DATA_W-1:0] sp_rdata,
  input  logic              wr0_en,
  input  logic [ADDR_W-1:0] wr0_addr,
  input  logic [DATA_W-1:0] wr0_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              sp_we,
  input  logic [DATA_W-1:0] sp_wdata,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             pending;
  logic [DEPTH-1:0]             we;
  logic [DEPTH-1:0][DATA_W-1:0] wdata;
  logic                         conflict;
  logic                         iss_eff;

  regfile_wr_arb #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .SPECIAL_IDX (SPECIAL_IDX),
    .ZERO_REG    (ZERO_REG)
  ) u_wr_arb (
    .wr0_en   (wr0_en),
    .wr0_addr (wr0_addr),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_addr (wr1_addr),
    .wr1_data (wr1_data),
    .sp_we    (sp_we),
    .sp_wdata (sp_wdata),
    .we       (we),
    .wdata    (wdata),
    .conflict (conflict)
  );

  assign iss_eff = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

  // Issue wins over a same-cycle write to the same register: the data still
  // lands but the destination stays pending for the newer instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs        <= '0;
      pending     <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we[i]) regs[i] <= wdata[i];
        if (iss_eff && (iss_addr == ADDR_W'(i))) pending[i] <= 1'b1;
        else if (we[i])                          pending[i] <= 1'b0;
      end
      wr_conflict <= conflict;
    end
  end

`ifdef REGFILE_MP_BYPASS_EN
  assign rd_data_a = we[rd_addr_a] ? wdata[rd_addr_a] : regs[rd_addr_a];
  assign rd_data_b = we[rd_addr_b] ? wdata[rd_addr_b] : regs[rd_addr_b];
  assign sp_rdata  = we[SPECIAL_IDX] ? wdata[SPECIAL_IDX] : regs[SPECIAL_IDX];
  assign rd_rdy_a  = we[rd_addr_a] ? !(iss_eff && (iss_addr == rd_addr_a))
                                   : !pending[rd_addr_a];
  assign rd_rdy_b  = we[rd_addr_b] ? !(iss_eff && (iss_addr == rd_addr_b))
                                   : !pending[rd_addr_b];
`else
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign sp_rdata  = regs[SPECIAL_IDX];
  assign rd_rdy_a  = !pending[rd_addr_a];
  assign rd_rdy_b  = !pending[rd_addr_b];
`endif

endmodule
